// File: rtl/alarm_set_ctrl.sv
// rtl/alarm_set_ctrl.sv - front-panel HH:MM time/alarm entry controller with debounced buttons
module alarm_set_ctrl #(
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int REPEAT_DELAY    = 10,
   parameter int REPEAT_RATE     = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_set,
   input  logic       btn_inc,
   output logic [1:0] H_in1,
   output logic [3:0] H_in0,
   output logic [3:0] M_in1,
   output logic [3:0] M_in0,
   output logic       LD_time,
   output logic       LD_alarm,
   output logic [1:0] edit_field,
   output logic       edit_target
);

   localparam int CW = 16;

   // Button index: 0 mode, 1 set, 2 inc
   typedef enum logic [2:0] {
      S_IDLE,
      S_T_HR,
      S_T_MIN,
      S_A_HR,
      S_A_MIN,
      S_LOAD
   } state_t;

   logic [2:0]    sync1_q, sync1_d;
   logic [2:0]    sync2_q, sync2_d;
   logic [2:0]    deb_q, deb_d;
   logic [CW-1:0] db_cnt_q [3];
   logic [CW-1:0] db_cnt_d [3];
   logic [2:0]    press_d;
   logic [2:0]    evt_q, evt_d;
   logic [CW-1:0] rep_cnt_q, rep_cnt_d;
   logic          rep_act_q, rep_act_d;
   logic          rep_fire;

   state_t        state_q, state_d;
   logic          ld_alarm_q, ld_alarm_d;
   logic [1:0]    h1_q, h1_d;
   logic [3:0]    h0_q, h0_d;
   logic [3:0]    m1_q, m1_d;
   logic [3:0]    m0_q, m0_d;

   logic          mode_ev, set_ev, inc_ev;

   // Synchronize raw buttons, then accept a level change only after it has been stable long enough
   always_comb begin
      sync1_d = {btn_inc, btn_set, btn_mode};
      sync2_d = sync1_q;
      deb_d   = deb_q;
      for (int i = 0; i < 3; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] + CW'(1) >= CW'(DEBOUNCE_CYCLES)) begin
               deb_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + CW'(1);
            end
         end
      end
      press_d = deb_d & ~deb_q;
   end

   // Auto-repeat for inc: first extra pulse REPEAT_DELAY cycles after the press, then every REPEAT_RATE
   always_comb begin
      rep_cnt_d = rep_cnt_q;
      rep_act_d = rep_act_q;
      rep_fire  = 1'b0;
      if (!deb_d[2] || press_d[2]) begin
         rep_cnt_d = '0;
         rep_act_d = 1'b0;
      end else if (REPEAT_DELAY != 0) begin
         if (!rep_act_q) begin
            if (rep_cnt_q + CW'(1) == CW'(REPEAT_DELAY)) begin
               rep_fire  = 1'b1;
               rep_cnt_d = '0;
               rep_act_d = 1'b1;
            end else begin
               rep_cnt_d = rep_cnt_q + CW'(1);
            end
         end else begin
            if (rep_cnt_q + CW'(1) >= CW'(REPEAT_RATE)) begin
               rep_fire  = 1'b1;
               rep_cnt_d = '0;
            end else begin
               rep_cnt_d = rep_cnt_q + CW'(1);
            end
         end
      end
      evt_d = {press_d[2] | rep_fire, press_d[1], press_d[0]};
   end

   // Resolve same-cycle events: mode beats set beats inc
   always_comb begin
      mode_ev = evt_q[0];
      set_ev  = evt_q[1] & ~evt_q[0];
      inc_ev  = evt_q[2] & ~evt_q[1] & ~evt_q[0];
   end

   // Next-state logic of the edit FSM
   always_comb begin
      state_d    = state_q;
      ld_alarm_d = ld_alarm_q;
      case (state_q)
         S_IDLE:  if (mode_ev) state_d = S_T_HR;
         S_T_HR: begin
            if (mode_ev)     state_d = S_A_HR;
            else if (set_ev) state_d = S_T_MIN;
         end
         S_A_HR: begin
            if (mode_ev)     state_d = S_IDLE;
            else if (set_ev) state_d = S_A_MIN;
         end
         S_T_MIN: begin
            if (mode_ev) begin
               state_d = S_IDLE;
            end else if (set_ev) begin
               state_d    = S_LOAD;
               ld_alarm_d = 1'b0;
            end
         end
         S_A_MIN: begin
            if (mode_ev) begin
               state_d = S_IDLE;
            end else if (set_ev) begin
               state_d    = S_LOAD;
               ld_alarm_d = 1'b1;
            end
         end
         S_LOAD:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Edit register: cleared on entry to an hours field, BCD increment of the active field
   always_comb begin
      h1_d = h1_q;
      h0_d = h0_q;
      m1_d = m1_q;
      m0_d = m0_q;
      if (mode_ev && (state_q == S_IDLE || state_q == S_T_HR)) begin
         h1_d = '0;
         h0_d = '0;
         m1_d = '0;
         m0_d = '0;
      end else if (inc_ev && (state_q == S_T_HR || state_q == S_A_HR)) begin
         if (h1_q == 2'd2 && h0_q == 4'd3) begin
            h1_d = '0;
            h0_d = '0;
         end else if (h0_q == 4'd9) begin
            h0_d = '0;
            h1_d = h1_q + 2'd1;
         end else begin
            h0_d = h0_q + 4'd1;
         end
      end else if (inc_ev && (state_q == S_T_MIN || state_q == S_A_MIN)) begin
         if (m0_q == 4'd9) begin
            m0_d = '0;
            m1_d = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
         end else begin
            m0_d = m0_q + 4'd1;
         end
      end
   end

   // Outputs decoded from the current state and edit register
   always_comb begin
      H_in1       = h1_q;
      H_in0       = h0_q;
      M_in1       = m1_q;
      M_in0       = m0_q;
      LD_time     = (state_q == S_LOAD) && !ld_alarm_q;
      LD_alarm    = (state_q == S_LOAD) && ld_alarm_q;
      edit_target = (state_q == S_A_HR) || (state_q == S_A_MIN);
      case (state_q)
         S_T_HR, S_A_HR:   edit_field = 2'd1;
         S_T_MIN, S_A_MIN: edit_field = 2'd2;
         default:          edit_field = 2'd0;
      endcase
   end

   // State register and all other flops, synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
         evt_q      <= '0;
         rep_cnt_q  <= '0;
         rep_act_q  <= 1'b0;
         state_q    <= S_IDLE;
         ld_alarm_q <= 1'b0;
         h1_q       <= '0;
         h0_q       <= '0;
         m1_q       <= '0;
         m0_q       <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         deb_q      <= deb_d;
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
         evt_q      <= evt_d;
         rep_cnt_q  <= rep_cnt_d;
         rep_act_q  <= rep_act_d;
         state_q    <= state_d;
         ld_alarm_q <= ld_alarm_d;
         h1_q       <= h1_d;
         h0_q       <= h0_d;
         m1_q       <= m1_d;
         m0_q       <= m0_d;
      end
   end

endmodule
